// File: rtl/rf_wb_queue_if.sv
// Bundle of the writeback-queue signals: result offer, register file drain port,
// decode read-port forwarding and status.
interface rf_wb_queue_if #(
  parameter int DEPTH = 4
);
  // Offer handshake: a result transfers on a cycle where in_valid & in_ready are both 1.
  // in_ready never depends on in_valid or on a same-cycle drain.
  logic                     in_valid;
  logic [2:0]               in_regsel;
  logic [15:0]              in_data;
  logic                     in_ready;
  logic                     rf_hold;
  logic                     write;
  logic [2:0]               writeregsel;
  logic [15:0]              writedata;
  logic [2:0]               read1regsel;
  logic [2:0]               read2regsel;
  logic                     read1hit;
  logic                     read2hit;
  logic [15:0]              read1fwd;
  logic [15:0]              read2fwd;
  logic [$clog2(DEPTH):0]   count;
  logic                     err;

  modport master (
    output in_valid, in_regsel, in_data, rf_hold, read1regsel, read2regsel,
    input  in_ready, write, writeregsel, writedata, read1hit, read2hit,
           read1fwd, read2fwd, count, err
  );

  modport slave (
    input  in_valid, in_regsel, in_data, rf_hold, read1regsel, read2regsel,
    output in_ready, write, writeregsel, writedata, read1hit, read2hit,
           read1fwd, read2fwd, count, err
  );
endinterface

// File: rtl/rf_wb_queue.sv
// Writeback queue: buffers completed results, drains one per cycle into the
// register file, and forwards the newest pending value to two read ports.
module rf_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  rf_wb_queue_if.slave  q
);
  localparam int        AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [2:0]   r_regsel [DEPTH];
  logic [15:0]  r_data   [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_err;

  logic          w_in_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_nonempty;
  logic [AW-1:0] w_idx;
  logic          w_hit1;
  logic          w_hit2;
  logic [15:0]   w_fwd1;
  logic [15:0]   w_fwd2;

  assign w_nonempty = (r_count != '0);
  assign w_in_ready = (r_count != FULL_CNT);
  assign w_push     = q.in_valid & w_in_ready;
  assign w_pop      = w_nonempty & ~q.rf_hold;

  // Walk oldest to newest so a later match overrides an earlier one.
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_fwd1 = '0;
    w_fwd2 = '0;
    w_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + AW'(i);
      if ((AW+1)'(i) < r_count) begin
        if (r_regsel[w_idx] == q.read1regsel) begin
          w_hit1 = 1'b1;
          w_fwd1 = r_data[w_idx];
        end
        if (r_regsel[w_idx] == q.read2regsel) begin
          w_hit2 = 1'b1;
          w_fwd2 = r_data[w_idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regsel[i] <= '0;
        r_data[i]   <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_regsel[r_wr_ptr] <= q.in_regsel;
        r_data[r_wr_ptr]   <= q.in_data;
        r_wr_ptr           <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      // A rejected offer is dropped; only the sticky flag records it.
      if (q.in_valid && !w_in_ready) begin
        r_err <= 1'b1;
      end
    end
  end

  assign q.in_ready    = w_in_ready;
  assign q.write       = w_pop;
  assign q.writeregsel = w_nonempty ? r_regsel[r_rd_ptr] : 3'd0;
  assign q.writedata   = w_nonempty ? r_data[r_rd_ptr]   : 16'd0;
  assign q.read1hit    = w_hit1;
  assign q.read2hit    = w_hit2;
  assign q.read1fwd    = w_fwd1;
  assign q.read2fwd    = w_fwd2;
  assign q.count       = r_count;
  assign q.err         = r_err;
endmodule
